// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the sliced serial subtractor.
//   SLICE_W     - width of one datapath slice
//   state_t     - sequencing states of the serial subtractor FSM
//   slice_count - width of the slice index for a given operand width
package arith_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // The index is never narrower than one bit, even for a single slice.
    function automatic int slice_count(input int width);
        int slices;
        slices = width / SLICE_W;
        return (slices <= 1) ? 1 : $clog2(slices);
    endfunction

endpackage

// File: rtl/sub_slice_4.sv
// Combinational 4-bit subtract with borrow: diff = a - b - b_in.
//   a, b  - 4-bit operands
//   b_in  - borrow into the slice
//   diff  - 4-bit difference
//   b_out - borrow out of the slice
module sub_slice_4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       b_in,
    output logic [3:0] diff,
    output logic       b_out
);

    logic [4:0] sum;

    // Subtraction as a + ~b + ~borrow; the carry out is the inverted borrow.
    assign sum   = {1'b0, a} + {1'b0, ~b} + {4'b0000, ~b_in};
    assign diff  = sum[3:0];
    assign b_out = ~sum[4];

endmodule

// File: rtl/slice_serial_subtractor.sv
// Multi-cycle subtractor: diff = (a - b - b_in) mod 2^bits, one 4-bit slice
// per clock with the borrow carried between slices in a register.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; operands and borrow-in latched on start
//   RUN   | one slice per cycle, index 0..n-1, borrow registered
//   DONE  | one-cycle done strobe, results valid, back to IDLE
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   start           - request, sampled only in IDLE
//   a, b, b_in      - minuend, subtrahend, borrow-in (captured on start)
//   busy            - operation in flight
//   done            - one-cycle result strobe
//   diff            - difference
//   b_out           - borrow out (a < b + b_in, unsigned)
//   ovf             - two's-complement overflow
//   zero            - diff == 0
module slice_serial_subtractor
    import arith_pkg::*;
#(
    parameter int n    = 4,
    parameter int bits = SLICE_W * n
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [bits-1:0] a,
    input  logic [bits-1:0] b,
    input  logic            b_in,
    output logic            busy,
    output logic            done,
    output logic [bits-1:0] diff,
    output logic            b_out,
    output logic            ovf,
    output logic            zero
);

    localparam int IDX_W = slice_count(bits);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(n - 1);

    state_t          state_q;
    state_t          state_d;
    logic [bits-1:0] a_q;
    logic [bits-1:0] b_q;
    logic [bits-1:0] diff_q;
    logic [bits-1:0] diff_d;
    logic            borrow_q;
    logic [IDX_W-1:0] idx_q;
    logic            b_out_q;
    logic            ovf_q;
    logic            zero_q;

    logic [IDX_W+1:0] lsb_pos;
    logic [3:0]      a_s;
    logic [3:0]      b_s;
    logic [3:0]      s_diff;
    logic            s_bout;
    logic            last_slice;

    // Slice width is 4, so the slice LSB position is the index shifted by 2.
    assign lsb_pos    = {idx_q, 2'b00};
    assign a_s        = a_q[lsb_pos +: 4];
    assign b_s        = b_q[lsb_pos +: 4];
    assign last_slice = (idx_q == LAST_IDX);

    sub_slice_4 u_slice (
        .a     (a_s),
        .b     (b_s),
        .b_in  (borrow_q),
        .diff  (s_diff),
        .b_out (s_bout)
    );

    // Full result with the current slice merged in; on the last slice this
    // is the final difference, so the flags can be registered alongside it.
    always_comb begin
        diff_d = diff_q;
        diff_d[lsb_pos +: 4] = s_diff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_slice) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q      <= a;
                        b_q      <= b;
                        borrow_q <= b_in;
                        idx_q    <= '0;
                    end
                end
                RUN: begin
                    diff_q   <= diff_d;
                    borrow_q <= s_bout;
                    idx_q    <= idx_q + IDX_W'(1);
                    if (last_slice) begin
                        b_out_q <= s_bout;
                        ovf_q   <= (a_q[bits-1] != b_q[bits-1]) &&
                                   (diff_d[bits-1] != a_q[bits-1]);
                        zero_q  <= (diff_d == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign diff  = diff_q;
    assign b_out = b_out_q;
    assign ovf   = ovf_q;
    assign zero  = zero_q;

endmodule

// File: tb/tb_slice_serial_subtractor.sv
module tb_slice_serial_subtractor;

    localparam int N16 = 4;
    localparam int N1  = 1;

    typedef struct packed {
        logic [15:0] diff;
        logic        b_out;
        logic        ovf;
        logic        zero;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    logic        start16, bin16, busy16, done16, bout16, ovf16, zero16;
    logic [15:0] a16, b16, diff16;

    logic        start1, bin1, busy1, done1, bout1, ovf1, zero1;
    logic [3:0]  a1, b1, diff1;

    int checks = 0;
    int errors = 0;

    exp_t q16[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    slice_serial_subtractor #(.n(N16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .b_in(bin16),
        .busy(busy16), .done(done16), .diff(diff16), .b_out(bout16),
        .ovf(ovf16), .zero(zero16)
    );

    slice_serial_subtractor #(.n(N1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .b_in(bin1),
        .busy(busy1), .done(done1), .diff(diff1), .b_out(bout1),
        .ovf(ovf1), .zero(zero1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model16(input logic [15:0] x, input logic [15:0] y, input logic bi);
        logic [16:0] full;
        exp_t e;
        full    = {1'b0, x} - {1'b0, y} - {16'h0000, bi};
        e.diff  = full[15:0];
        e.b_out = full[16];
        e.ovf   = (x[15] != y[15]) && (full[15] != x[15]);
        e.zero  = (full[15:0] == 16'h0000);
        return e;
    endfunction

    function automatic exp_t model4(input logic [3:0] x, input logic [3:0] y, input logic bi);
        logic [4:0] full;
        exp_t e;
        full    = {1'b0, x} - {1'b0, y} - {4'h0, bi};
        e.diff  = {12'h000, full[3:0]};
        e.b_out = full[4];
        e.ovf   = (x[3] != y[3]) && (full[3] != x[3]);
        e.zero  = (full[3:0] == 4'h0);
        return e;
    endfunction

    // Tasks are entered and left 1 time unit after a rising edge.
    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                        input bit disturb);
        exp_t e;
        int   k;
        bit   got;
        a16 = av; b16 = bv; bin16 = bi; start16 = 1'b1;
        q16.push_back(model16(av, bv, bi));
        @(posedge clk); #1;
        start16 = 1'b0;
        chk("busy_at_start", busy16, 1);
        chk("done_at_start", done16, 0);
        k = 0; got = 0;
        while (!got && k < 40) begin
            if (disturb && k < N16) begin
                start16 = (k == 1);
                a16     = (k == 1) ? 16'hFFFF : 16'($urandom);
                b16     = 16'($urandom);
                bin16   = 1'($urandom);
            end
            @(posedge clk); #1;
            start16 = 1'b0;
            k++;
            if (done16) got = 1;
            else chk("busy_in_run", busy16, 1);
        end
        chk("latency16", k, N16);
        if (got && q16.size() > 0) begin
            e = q16.pop_front();
            chk("diff16", diff16, e.diff);
            chk("b_out16", bout16, e.b_out);
            chk("ovf16", ovf16, e.ovf);
            chk("zero16", zero16, e.zero);
            chk("busy_with_done16", busy16, 0);
            @(posedge clk); #1;
            chk("done_width16", done16, 0);
            chk("diff_hold16", diff16, e.diff);
            chk("b_out_hold16", bout16, e.b_out);
        end else begin
            q16.delete();
        end
        if (disturb) begin
            repeat (N16 + 3) begin
                @(posedge clk); #1;
                chk("no_second_done", done16, 0);
                chk("no_second_busy", busy16, 0);
            end
        end
    endtask

    task automatic op1(input logic [3:0] av, input logic [3:0] bv, input logic bi);
        exp_t e;
        int   k;
        bit   got;
        a1 = av; b1 = bv; bin1 = bi; start1 = 1'b1;
        q1.push_back(model4(av, bv, bi));
        @(posedge clk); #1;
        start1 = 1'b0;
        a1 = 4'($urandom); b1 = 4'($urandom);
        chk("busy1_at_start", busy1, 1);
        k = 0; got = 0;
        while (!got && k < 20) begin
            @(posedge clk); #1;
            k++;
            if (done1) got = 1;
        end
        chk("latency1", k, N1);
        if (got && q1.size() > 0) begin
            e = q1.pop_front();
            chk("diff1", diff1, e.diff[3:0]);
            chk("b_out1", bout1, e.b_out);
            chk("ovf1", ovf1, e.ovf);
            chk("zero1", zero1, e.zero);
            chk("busy1_with_done", busy1, 0);
            @(posedge clk); #1;
        end else begin
            q1.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
        start1  = 1'b0; a1  = '0; b1  = '0; bin1  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy16, 0);
        chk("rst_done", done16, 0);
        chk("rst_diff", diff16, 0);
        chk("rst_flags", {bout16, ovf16, zero16}, 0);
        chk("rst1_outs", {busy1, done1, diff1, bout1, ovf1, zero1}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        op16(16'h1234, 16'h0234, 1'b0, 0);
        op16(16'h1000, 16'h0001, 1'b0, 0);
        op16(16'h0000, 16'h0001, 1'b0, 0);
        op16(16'h8000, 16'h0001, 1'b0, 0);
        op16(16'h00FF, 16'h00FE, 1'b1, 0);
        op16(16'h7FFF, 16'hFFFF, 1'b0, 0);
        op16(16'hFFFF, 16'hFFFF, 1'b1, 0);
        op16(16'h0005, 16'h0003, 1'b0, 1);

        // Reset during the second RUN cycle discards the operation.
        a16 = 16'h4321; b16 = 16'h1111; bin16 = 1'b0; start16 = 1'b1;
        @(posedge clk); #1;
        start16 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", busy16, 0);
        chk("midrst_done", done16, 0);
        chk("midrst_diff", diff16, 0);
        chk("midrst_flags", {bout16, ovf16, zero16}, 0);
        repeat (N16 + 3) begin
            @(posedge clk); #1;
            chk("midrst_no_done", done16, 0);
        end
        op16(16'h4321, 16'h1111, 1'b0, 0);

        for (int i = 0; i < 6; i++) begin
            op16(16'($urandom), 16'($urandom), 1'($urandom), 0);
        end

        op1(4'h3, 4'h5, 1'b0);
        op1(4'h8, 4'h1, 1'b0);
        op1(4'h6, 4'h5, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
